// File: rtl/rule_packer_32_64.sv
// rule_packer_32_64: packs non-zero 32-bit rule IDs two per 64-bit word
// (earlier rule in the low half) and closes every packet with a single
// zero-data eop word. A small output FIFO decouples the packer from the
// downstream ready so in_rule_ready depends on registered state only.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. A producer keeps its fields stable while valid && !ready.
module rule_packer_32_64 #(
   parameter int BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_rule_sop,
   input  logic        in_rule_eop,
   input  logic [1:0]  in_rule_empty,
   input  logic        in_rule_valid,
   input  logic [31:0] in_rule_data,
   output logic        in_rule_ready,
   output logic        out_rule_sop,
   output logic        out_rule_eop,
   output logic        out_rule_valid,
   output logic [63:0] out_rule_data,
   output logic [2:0]  out_rule_empty,
   input  logic        out_rule_ready,
   output logic        fsm_state
);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);

   state_t        state, state_nxt;
   logic [31:0]   latch, latch_nxt;
   logic          pend, pend_nxt;
   logic          sop_flag, sop_flag_nxt;

   // FIFO entry layout: {sop, eop, data[63:0]}
   logic [65:0]   mem [BUF_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [65:0]   head;

   logic          push;
   logic [65:0]   push_word;
   logic          pop;
   logic          accept;
   logic          eff_sop;
   logic          unused_empty;

   // The input empty field carries no information for this block.
   assign unused_empty = ^in_rule_empty;

   assign in_rule_ready = !rst && (state == RUN) && (count < CW'(BUF_DEPTH));
   assign accept        = in_rule_valid && in_rule_ready;
   assign pop           = out_rule_valid && out_rule_ready;
   assign eff_sop       = sop_flag | (accept & in_rule_sop);
   assign fsm_state     = (state == FLUSH);

   // Next-state, packing decisions and the single FIFO push per cycle.
   always_comb begin
      state_nxt    = state;
      latch_nxt    = latch;
      pend_nxt     = pend;
      sop_flag_nxt = sop_flag;
      push         = 1'b0;
      push_word    = '0;
      case (state)
         RUN: begin
            if (accept) begin
               if (in_rule_eop) begin
                  push         = 1'b1;
                  sop_flag_nxt = 1'b0;
                  if (pend) begin
                     // Partial word first; the eop word follows from FLUSH.
                     push_word = {eff_sop, 1'b0, 32'h0, latch};
                     pend_nxt  = 1'b0;
                     state_nxt = FLUSH;
                  end else begin
                     push_word = {eff_sop, 1'b1, 64'h0};
                  end
               end else if (in_rule_data == 32'h0) begin
                  // Dropped beat still carries its sop forward.
                  sop_flag_nxt = eff_sop;
               end else if (!pend) begin
                  latch_nxt    = in_rule_data;
                  pend_nxt     = 1'b1;
                  sop_flag_nxt = eff_sop;
               end else begin
                  push         = 1'b1;
                  push_word    = {eff_sop, 1'b0, in_rule_data, latch};
                  pend_nxt     = 1'b0;
                  sop_flag_nxt = 1'b0;
               end
            end
         end
         FLUSH: begin
            if ((count < CW'(BUF_DEPTH)) || pop) begin
               push         = 1'b1;
               push_word    = {sop_flag, 1'b1, 64'h0};
               sop_flag_nxt = 1'b0;
               state_nxt    = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // Packer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         latch    <= '0;
         pend     <= 1'b0;
         sop_flag <= 1'b0;
      end else begin
         state    <= state_nxt;
         latch    <= latch_nxt;
         pend     <= pend_nxt;
         sop_flag <= sop_flag_nxt;
      end
   end

   // FIFO pointers and occupancy; pointers wrap modulo BUF_DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage; contents are only observed while count != 0.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_word;
   end

   assign head           = mem[rd_ptr];
   assign out_rule_valid = (count != '0);
   assign out_rule_sop   = out_rule_valid & head[65];
   assign out_rule_eop   = out_rule_valid & head[64];
   assign out_rule_data  = out_rule_valid ? head[63:0] : 64'h0;
   assign out_rule_empty = 3'b000;

endmodule

// File: tb/tb_rule_packer_32_64.sv
// Directed bench for rule_packer_32_64: reset, packing, zero suppression,
// sop carry, flush, backpressure, randomized round trip and reset mid-packet.
module tb_rule_packer_32_64;

   localparam int DEPTH = 3;

   logic        clk;
   logic        rst;
   logic        in_rule_sop;
   logic        in_rule_eop;
   logic [1:0]  in_rule_empty;
   logic        in_rule_valid;
   logic [31:0] in_rule_data;
   logic        in_rule_ready;
   logic        out_rule_sop;
   logic        out_rule_eop;
   logic        out_rule_valid;
   logic [63:0] out_rule_data;
   logic [2:0]  out_rule_empty;
   logic        out_rule_ready;
   logic        fsm_state;

   int checks = 0;
   int errors = 0;
   int low_cnt = 0;
   logic [65:0] got_q[$];
   logic [65:0] exp_q[$];

   rule_packer_32_64 #(.BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_rule_sop(in_rule_sop), .in_rule_eop(in_rule_eop),
      .in_rule_empty(in_rule_empty), .in_rule_valid(in_rule_valid),
      .in_rule_data(in_rule_data), .in_rule_ready(in_rule_ready),
      .out_rule_sop(out_rule_sop), .out_rule_eop(out_rule_eop),
      .out_rule_valid(out_rule_valid), .out_rule_data(out_rule_data),
      .out_rule_empty(out_rule_empty), .out_rule_ready(out_rule_ready),
      .fsm_state(fsm_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: a word seen valid&&ready at negedge transfers at the next posedge.
   always @(negedge clk) begin
      if (!rst && out_rule_valid && out_rule_ready)
         got_q.push_back({out_rule_sop, out_rule_eop, out_rule_data});
      if (!rst && !in_rule_ready) low_cnt++;
   end

   // Drive one beat; called and returns at posedge+1.
   task automatic send(input logic s, input logic e, input logic [31:0] d);
      int n = 0;
      in_rule_valid = 1'b1;
      in_rule_sop   = s;
      in_rule_eop   = e;
      in_rule_data  = d;
      @(negedge clk);
      while (!in_rule_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++; errors++;
         $display("FAIL send_timeout got ready=%b required 1", in_rule_ready);
      end
      @(posedge clk); #1;
      in_rule_valid = 1'b0;
      in_rule_sop   = 1'b0;
      in_rule_eop   = 1'b0;
      in_rule_data  = 32'h0;
   endtask

   // Wait until the block is idle with an empty FIFO.
   task automatic wait_drain(input string name);
      int idle = 0;
      int n = 0;
      while (idle < 3 && n < 500) begin
         @(negedge clk);
         n++;
         if (!out_rule_valid && in_rule_ready) idle++;
         else idle = 0;
      end
      if (idle < 3) begin
         checks++; errors++;
         $display("FAIL %s_drain got valid=%b required 0", name, out_rule_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (out_rule_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", out_rule_valid); end
      checks++; if (out_rule_sop !== 1'b0) begin errors++; $display("FAIL reset_sop got %b required 0", out_rule_sop); end
      checks++; if (out_rule_eop !== 1'b0) begin errors++; $display("FAIL reset_eop got %b required 0", out_rule_eop); end
      checks++; if (out_rule_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h required 0", out_rule_data); end
      checks++; if (out_rule_empty !== 3'b000) begin errors++; $display("FAIL reset_empty got %b required 0", out_rule_empty); end
      checks++; if (in_rule_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b required 0", in_rule_ready); end
      checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b required 0", fsm_state); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_rule_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b required 1", in_rule_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_even_packet;
      int base = got_q.size();
      exp_q = '{{2'b10, 64'h00000022_00000011}, {2'b00, 64'h00000044_00000033}, {2'b01, 64'h0}};
      send(1, 0, 32'h11); send(0, 0, 32'h22); send(0, 0, 32'h33); send(0, 0, 32'h44); send(0, 1, 32'h0);
      wait_drain("even");
      checks++;
      if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL even_count got %0d required %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) if (base + i < got_q.size()) begin
         checks++;
         if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL even_word%0d got %h required %h", i, got_q[base + i], exp_q[i]); end
      end
   endtask

   task automatic test_odd_packet;
      int base = got_q.size();
      int low0 = low_cnt;
      exp_q = '{{2'b10, 64'h00000006_00000005}, {2'b00, 64'h00000000_00000007}, {2'b01, 64'h0}};
      send(1, 0, 32'h5); send(0, 0, 32'h6); send(0, 0, 32'h7); send(0, 1, 32'h0);
      wait_drain("odd");
      checks++;
      if (low_cnt - low0 !== 1) begin errors++; $display("FAIL odd_flush_cycles got %0d required 1", low_cnt - low0); end
      checks++;
      if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL odd_count got %0d required %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) if (base + i < got_q.size()) begin
         checks++;
         if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL odd_word%0d got %h required %h", i, got_q[base + i], exp_q[i]); end
      end
   endtask

   task automatic test_zero_suppression;
      int base = got_q.size();
      exp_q = '{{2'b10, 64'h0000000B_0000000A}, {2'b01, 64'h0}};
      send(1, 0, 32'h0); send(0, 0, 32'hA); send(0, 0, 32'h0); send(0, 0, 32'hB); send(0, 1, 32'h0);
      wait_drain("zero");
      checks++;
      if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL zero_count got %0d required %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) if (base + i < got_q.size()) begin
         checks++;
         if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL zero_word%0d got %h required %h", i, got_q[base + i], exp_q[i]); end
      end
   endtask

   task automatic test_empty_packet;
      int base = got_q.size();
      exp_q = '{{2'b11, 64'h0}};
      send(1, 1, 32'hDEAD_BEEF);
      wait_drain("empty");
      checks++;
      if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL empty_count got %0d required %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) if (base + i < got_q.size()) begin
         checks++;
         if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL empty_word%0d got %h required %h", i, got_q[base + i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back;
      int base = got_q.size();
      exp_q = '{{2'b10, 64'h00000002_00000001}, {2'b00, 64'h00000000_00000003}, {2'b01, 64'h0},
                {2'b10, 64'h00000000_00000004}, {2'b01, 64'h0}};
      send(1, 0, 32'h1); send(0, 0, 32'h2); send(0, 0, 32'h3); send(0, 1, 32'h0);
      send(1, 0, 32'h4); send(0, 1, 32'h0);
      wait_drain("b2b");
      checks++;
      if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d required %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) if (base + i < got_q.size()) begin
         checks++;
         if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d got %h required %h", i, got_q[base + i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure;
      int base = got_q.size();
      bit done = 0;
      int n = 0;
      exp_q = '{{2'b10, 64'h00000002_00000001}, {2'b00, 64'h00000004_00000003},
                {2'b00, 64'h00000006_00000005}, {2'b00, 64'h00000008_00000007}, {2'b01, 64'h0}};
      out_rule_ready = 1'b0;
      fork
         begin
            send(1, 0, 32'h1);
            for (int k = 2; k <= 8; k++) send(0, 0, k);
            send(0, 1, 32'h0);
            done = 1;
         end
      join_none
      repeat (10) @(negedge clk);
      checks++; if (in_rule_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b required 0", in_rule_ready); end
      checks++; if (out_rule_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b required 1", out_rule_valid); end
      checks++;
      if ({out_rule_sop, out_rule_eop, out_rule_data} !== {2'b10, 64'h00000002_00000001}) begin
         errors++; $display("FAIL bp_head_held got %h required %h", {out_rule_sop, out_rule_eop, out_rule_data}, {2'b10, 64'h00000002_00000001});
      end
      @(posedge clk); #1;
      out_rule_ready = 1'b1;
      while (!done && n < 500) begin @(posedge clk); n++; end
      #1;
      checks++; if (!done) begin errors++; $display("FAIL bp_sender got done=%0d required 1", done); end
      wait_drain("bp");
      checks++;
      if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d required %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) if (base + i < got_q.size()) begin
         checks++;
         if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d got %h required %h", i, got_q[base + i], exp_q[i]); end
      end
   endtask

   // Random valid/ready; words are unpacked by a depacker model and compared
   // against the non-zero rule stream with packet markers.
   task automatic test_random;
      logic [33:0] beats[$];
      logic [32:0] exp_r[$];
      logic [32:0] got_r[$];
      logic [65:0] w;
      int base = got_q.size();
      int idx = 0;
      int guard = 0;
      bit acc;
      bit want_sop;
      for (int p = 0; p < 6; p++) begin
         int len = $urandom_range(0, 12);
         for (int k = 0; k < len; k++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 100000));
            beats.push_back({k == 0, 1'b0, d});
            if (d != 32'h0) exp_r.push_back({1'b0, d});
         end
         beats.push_back({len == 0, 1'b1, 32'($urandom)});
         exp_r.push_back({1'b1, 32'h0});
      end
      while (idx < beats.size() && guard < 20000) begin
         out_rule_ready = ($urandom_range(0, 3) != 0);
         in_rule_valid  = ($urandom_range(0, 3) != 0);
         {in_rule_sop, in_rule_eop, in_rule_data} = beats[idx];
         @(negedge clk);
         acc = in_rule_valid && in_rule_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         guard++;
      end
      in_rule_valid = 1'b0;
      in_rule_sop = 1'b0;
      in_rule_eop = 1'b0;
      out_rule_ready = 1'b1;
      checks++; if (idx != beats.size()) begin errors++; $display("FAIL rand_sent got %0d required %0d", idx, beats.size()); end
      wait_drain("rand");
      want_sop = 1;
      for (int i = base; i < got_q.size(); i++) begin
         w = got_q[i];
         checks++;
         if (w[65] !== want_sop) begin errors++; $display("FAIL rand_sop%0d got %b required %b", i - base, w[65], want_sop); end
         if (w[64]) begin
            checks++;
            if (w[63:0] !== 64'h0) begin errors++; $display("FAIL rand_eop_data got %h required 0", w[63:0]); end
            got_r.push_back({1'b1, 32'h0});
         end else begin
            got_r.push_back({1'b0, w[31:0]});
            if (w[63:32] != 32'h0) got_r.push_back({1'b0, w[63:32]});
         end
         want_sop = w[64];
      end
      checks++;
      if (got_r.size() !== exp_r.size()) begin errors++; $display("FAIL rand_count got %0d required %0d", got_r.size(), exp_r.size()); end
      for (int i = 0; i < exp_r.size(); i++) if (i < got_r.size()) begin
         checks++;
         if (got_r[i] !== exp_r[i]) begin errors++; $display("FAIL rand_rule%0d got %h required %h", i, got_r[i], exp_r[i]); end
      end
   endtask

   task automatic test_reset_mid_packet;
      int base;
      out_rule_ready = 1'b0;
      send(1, 0, 32'h1); send(0, 0, 32'h2); send(0, 0, 32'h3); send(0, 0, 32'h4); send(0, 0, 32'h5);
      @(negedge clk);
      checks++; if (out_rule_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b required 1", out_rule_valid); end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++; if (out_rule_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b required 0", out_rule_valid); end
      checks++; if (out_rule_data !== 64'h0) begin errors++; $display("FAIL mid_rst_data got %h required 0", out_rule_data); end
      checks++; if (out_rule_sop !== 1'b0) begin errors++; $display("FAIL mid_rst_sop got %b required 0", out_rule_sop); end
      checks++; if (in_rule_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b required 0", in_rule_ready); end
      @(negedge clk); @(negedge clk);
      checks++; if (out_rule_valid !== 1'b0 || in_rule_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_held got valid=%b ready=%b required 0 0", out_rule_valid, in_rule_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      out_rule_ready = 1'b1;
      base = got_q.size();
      exp_q = '{{2'b10, 64'h00000002_00000001}, {2'b01, 64'h0}};
      send(1, 0, 32'h1); send(0, 0, 32'h2); send(0, 1, 32'h0);
      wait_drain("mid");
      checks++;
      if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL mid_count got %0d required %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) if (base + i < got_q.size()) begin
         checks++;
         if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL mid_word%0d got %h required %h", i, got_q[base + i], exp_q[i]); end
      end
   endtask

   initial begin
      rst            = 1'b1;
      in_rule_sop    = 1'b0;
      in_rule_eop    = 1'b0;
      in_rule_empty  = 2'b11;
      in_rule_valid  = 1'b0;
      in_rule_data   = 32'h0;
      out_rule_ready = 1'b1;
      test_reset;
      test_even_packet;
      test_odd_packet;
      test_zero_suppression;
      test_empty_packet;
      test_back_to_back;
      test_backpressure;
      test_random;
      test_reset_mid_packet;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
